sprite_line_scheduler: RTL and testbench

Per-scanline sprite scheduler for the HDMI sprite pipeline. During each line it scans a sprite attribute table, selects up to `SLOTS` sprites that intersect the next line, and fetches their 8-bit bitmap rows into a shadow slot bank. At the next line start the shadow bank becomes active and drives a registered per-pixel "sprite on" and index output to the pixel mux ahead of `hdmi_tx`. Sprites are monochrome 8x8; colour selection is downstream.

---
 rtl/sprite_pkg.sv | 30 +++
 rtl/sprite_slot.sv | 44 ++++
 rtl/sprite_line_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the per-scanline sprite scheduler.
//   X_W / Y_W  : signed coordinate widths for columns and rows
//   SPR_SIZE   : sprites are SPR_SIZE x SPR_SIZE monochrome bitmaps
//   IDX_MAX_W  : sprite index width large enough for the biggest table (64)
//   sched_state_e : scheduler FSM states
//   slot_t     : one drawable slot {valid, x, row bitmap, sprite index}
package sprite_pkg;

  localparam int X_W       = 12;
  localparam int Y_W       = 11;
  localparam int SPR_SIZE  = 8;
  localparam int IDX_MAX_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_EVAL,
    ST_FETCH,
    ST_LOAD,
    ST_DONE
  } sched_state_e;

  typedef struct packed {
    logic                  valid;
    logic signed [X_W-1:0] x;
    logic [SPR_SIZE-1:0]   row;
    logic [IDX_MAX_W-1:0]  idx;
  } slot_t;

endpackage

// File: rtl/sprite_slot.sv
// sprite_slot: one active drawing slot.
//   clk, reset : clock and synchronous active-high reset (slot becomes invalid)
//   load       : copy slot_in into the active slot (bank swap)
//   slot_in    : shadow slot record to become active
//   h_pix      : current pixel column
//   opaque     : combinational, the slot covers h_pix with a set bitmap bit
//   idx        : sprite index held by the slot
module sprite_slot
  import sprite_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  slot_t                 slot_in,
  input  logic signed [X_W-1:0] h_pix,
  output logic                  opaque,
  output logic [IDX_MAX_W-1:0]  idx
);

  slot_t                 slot_q, slot_d;
  logic signed [X_W-1:0] e;

  always_comb begin
    slot_d = slot_q;
    if (load) slot_d = slot_in;
  end

  always_ff @(posedge clk) begin
    if (reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  // e in 0..7 means non-negative with all bits above bit 2 clear;
  // the leftmost pixel is bitmap bit 7, so the bit index is 7-e = ~e[2:0].
  always_comb begin
    e      = h_pix - slot_q.x;
    opaque = 1'b0;
    if (slot_q.valid && !e[X_W-1] && (e[X_W-2:3] == '0))
      opaque = slot_q.row[~e[2:0]];
  end

  assign idx = slot_q.idx;

endmodule

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: scans the sprite attribute table during each line,
// loads up to SLOTS sprites hitting next_y into a shadow bank, swaps the bank
// active on line_start and renders a registered pix_on/pix_idx per column.
//   clk, reset          : pixel clock, synchronous active-high reset
//   line_start/frame_start : timing pulses
//   next_y, horizontalPix  : row being scheduled, current column
//   attr_addr/attr_rd, attr_en/attr_x/attr_y : attribute table port (1-cycle read)
//   bmp_addr/bmp_rd, bmp_data : bitmap row port (1-cycle read)
//   pix_on, pix_idx     : registered winning pixel
//   overflow            : sticky, too many hits or a late scan this frame
// Optional: define SPR_COLLISION_EN to add the sticky `collision` output.
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 16,
  parameter int SLOTS       = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             line_start,
  input  logic                             frame_start,
  input  logic signed [Y_W-1:0]            next_y,
  input  logic signed [X_W-1:0]            horizontalPix,
  output logic [$clog2(NUM_SPRITES)-1:0]   attr_addr,
  output logic                             attr_rd,
  input  logic                             attr_en,
  input  logic signed [X_W-1:0]            attr_x,
  input  logic signed [Y_W-1:0]            attr_y,
  output logic [$clog2(NUM_SPRITES)+2:0]   bmp_addr,
  output logic                             bmp_rd,
  input  logic [SPR_SIZE-1:0]              bmp_data,
  output logic                             pix_on,
  output logic [$clog2(NUM_SPRITES)-1:0]   pix_idx,
  output logic                             overflow
`ifdef SPR_COLLISION_EN
  ,
  output logic                             collision
`endif
);

  localparam int IW = $clog2(NUM_SPRITES);
  localparam int CW = $clog2(SLOTS + 1);

  sched_state_e          state_q, state_d;
  logic [IW-1:0]         i_q, i_d;
  logic [CW-1:0]         n_q, n_d;
  logic                  attr_rd_q, attr_rd_d;
  logic [IW-1:0]         attr_addr_q, attr_addr_d;
  logic                  bmp_rd_q, bmp_rd_d;
  logic [IW+2:0]         bmp_addr_q, bmp_addr_d;
  logic signed [X_W-1:0] x_pend_q, x_pend_d;
  slot_t                 shadow_q [SLOTS];
  slot_t                 shadow_d [SLOTS];
  logic                  overflow_q, overflow_d;
  logic                  pix_on_q, pix_on_d;
  logic [IW-1:0]         pix_idx_q, pix_idx_d;

  logic                  swap, ovf_set, hit, last;
  logic signed [Y_W:0]   d;
  slot_t                 new_slot;
  logic [SLOTS-1:0]      opaque;
  logic [IDX_MAX_W-1:0]  slot_idx [SLOTS];
  logic [IDX_MAX_W-1:0]  win_idx;
  logic                  win_found;
  logic                  unused_idx;

  // Row offset is formed one bit wider than the coordinates so it never wraps.
  always_comb begin
    d    = {next_y[Y_W-1], next_y} - {attr_y[Y_W-1], attr_y};
    hit  = attr_en && !d[Y_W] && (d[Y_W-1:3] == '0);
    last = (i_q == IW'(NUM_SPRITES - 1));
    new_slot.valid = 1'b1;
    new_slot.x     = x_pend_q;
    new_slot.row   = bmp_data;
    new_slot.idx   = IDX_MAX_W'(i_q);
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    n_d         = n_q;
    attr_rd_d   = 1'b0;
    attr_addr_d = attr_addr_q;
    bmp_rd_d    = 1'b0;
    bmp_addr_d  = bmp_addr_q;
    x_pend_d    = x_pend_q;
    shadow_d    = shadow_q;
    swap        = 1'b0;
    ovf_set     = 1'b0;
    if (line_start) begin
      // Bank swap and scan restart take priority over any step in flight;
      // a LOAD in this cycle is dropped because the shadow is cleared here.
      swap = 1'b1;
      if (state_q != ST_IDLE && state_q != ST_DONE) ovf_set = 1'b1;
      for (int k = 0; k < SLOTS; k++) shadow_d[k] = '0;
      state_d     = ST_ADDR;
      i_d         = '0;
      n_d         = '0;
      attr_rd_d   = 1'b1;
      attr_addr_d = '0;
    end else begin
      case (state_q)
        ST_ADDR: state_d = ST_EVAL;
        ST_EVAL: begin
          if (hit) begin
            if (n_q == CW'(SLOTS)) begin
              ovf_set = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d    = ST_FETCH;
              bmp_rd_d   = 1'b1;
              bmp_addr_d = {i_q, d[2:0]};
              x_pend_d   = attr_x;
            end
          end else if (last) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_ADDR;
            i_d         = i_q + 1'b1;
            attr_rd_d   = 1'b1;
            attr_addr_d = i_q + 1'b1;
          end
        end
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          for (int k = 0; k < SLOTS; k++)
            if (n_q == CW'(k)) shadow_d[k] = new_slot;
          n_d = n_q + 1'b1;
          if (last) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_ADDR;
            i_d         = i_q + 1'b1;
            attr_rd_d   = 1'b1;
            attr_addr_d = i_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    // A set in the same cycle as frame_start wins.
    overflow_d = ovf_set ? 1'b1 : (frame_start ? 1'b0 : overflow_q);
  end

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      sprite_slot u_slot (
        .clk     (clk),
        .reset   (reset),
        .load    (swap),
        .slot_in (shadow_q[gi]),
        .h_pix   (horizontalPix),
        .opaque  (opaque[gi]),
        .idx     (slot_idx[gi])
      );
    end
  endgenerate

  // Scan from the top slot down so the lowest opaque slot is the last writer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if (opaque[k]) begin
        win_found = 1'b1;
        win_idx   = slot_idx[k];
      end
    end
    pix_on_d  = win_found;
    pix_idx_d = win_found ? win_idx[IW-1:0] : pix_idx_q;
  end

  assign unused_idx = ^win_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      n_q         <= '0;
      attr_rd_q   <= 1'b0;
      attr_addr_q <= '0;
      bmp_rd_q    <= 1'b0;
      bmp_addr_q  <= '0;
      x_pend_q    <= '0;
      overflow_q  <= 1'b0;
      pix_on_q    <= 1'b0;
      pix_idx_q   <= '0;
      for (int k = 0; k < SLOTS; k++) shadow_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      n_q         <= n_d;
      attr_rd_q   <= attr_rd_d;
      attr_addr_q <= attr_addr_d;
      bmp_rd_q    <= bmp_rd_d;
      bmp_addr_q  <= bmp_addr_d;
      x_pend_q    <= x_pend_d;
      overflow_q  <= overflow_d;
      pix_on_q    <= pix_on_d;
      pix_idx_q   <= pix_idx_d;
      shadow_q    <= shadow_d;
    end
  end

  assign attr_rd   = attr_rd_q;
  assign attr_addr = attr_addr_q;
  assign bmp_rd    = bmp_rd_q;
  assign bmp_addr  = bmp_addr_q;
  assign pix_on    = pix_on_q;
  assign pix_idx   = pix_idx_q;
  assign overflow  = overflow_q;

`ifdef SPR_COLLISION_EN
  logic collision_q, collision_d;
  logic multi, seen;

  always_comb begin
    multi = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      multi = multi | (seen & opaque[k]);
      seen  = seen | opaque[k];
    end
    collision_d = multi ? 1'b1 : (frame_start ? 1'b0 : collision_q);
  end

  always_ff @(posedge clk) begin
    if (reset) collision_q <= 1'b0;
    else       collision_q <= collision_d;
  end

  assign collision = collision_q;
`endif

endmodule

// File: tb/tb_sprite_line_scheduler.sv
`timescale 1ns/1ps
module tb_sprite_line_scheduler;
  import sprite_pkg::*;

  localparam int NS     = 16;
  localparam int NSL    = 4;
  localparam int IDLE_Y = -1000;
  localparam int IDLE_H = -1000;

  logic               clk = 1'b0;
  logic               reset, line_start, frame_start;
  logic signed [10:0] next_y;
  logic signed [11:0] horizontalPix;
  logic [3:0]         attr_addr;
  logic               attr_rd, attr_en;
  logic signed [11:0] attr_x;
  logic signed [10:0] attr_y;
  logic [6:0]         bmp_addr, last_bmp_addr;
  logic               bmp_rd;
  logic [7:0]         bmp_data;
  logic               pix_on, overflow;
  logic [3:0]         pix_idx;
`ifdef SPR_COLLISION_EN
  logic               collision;
  bit                 exp_coll;
`endif

  int total = 0;
  int bad   = 0;

  // attribute/bitmap memories and reference model state
  bit         t_en  [NS];
  int         t_x   [NS];
  int         t_y   [NS];
  logic [7:0] t_bmp [NS*8];
  int         m_n;
  int         m_slot [NSL];
  logic [7:0] m_row  [NSL];
  bit         m_ovf;
  int         exp_idx;

  sprite_line_scheduler #(.NUM_SPRITES(NS), .SLOTS(NSL)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .frame_start(frame_start),
    .next_y(next_y), .horizontalPix(horizontalPix),
    .attr_addr(attr_addr), .attr_rd(attr_rd), .attr_en(attr_en), .attr_x(attr_x), .attr_y(attr_y),
    .bmp_addr(bmp_addr), .bmp_rd(bmp_rd), .bmp_data(bmp_data),
    .pix_on(pix_on), .pix_idx(pix_idx), .overflow(overflow)
`ifdef SPR_COLLISION_EN
    , .collision(collision)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (attr_rd) begin
      attr_en <= t_en[attr_addr];
      attr_x  <= 12'(t_x[attr_addr]);
      attr_y  <= 11'(t_y[attr_addr]);
    end
    if (bmp_rd) begin
      bmp_data      <= t_bmp[bmp_addr];
      last_bmp_addr <= bmp_addr;
    end
  end

  // Which sprites end up in the shadow bank when the next line_start comes
  // c cycles after the one that began the scan (ADDR+EVAL per sprite,
  // FETCH+LOAD per hit).
  function automatic void model_scan(input int ny, input int c);
    int t;
    t = 1; m_n = 0; m_ovf = 0;
    for (int s = 0; s < NS; s++) begin
      int d;
      bit h;
      if (t + 1 >= c) begin m_ovf = 1; return; end
      d = ny - t_y[s];
      h = t_en[s] && d >= 0 && d <= 7;
      if (!h) t += 2;
      else if (m_n == NSL) begin m_ovf = 1; return; end
      else if (t + 3 >= c) begin m_ovf = 1; return; end
      else begin
        m_slot[m_n] = s;
        m_row[m_n]  = t_bmp[s*8 + d];
        m_n++;
        t += 4;
      end
    end
  endfunction

  function automatic int model_count(input int h, output int winner);
    int cnt;
    logic [7:0] r;
    cnt = 0; winner = -1;
    for (int k = 0; k < m_n; k++) begin
      int e;
      e = h - t_x[m_slot[k]];
      r = m_row[k];
      if (e >= 0 && e <= 7 && r[7-e]) begin
        if (winner < 0) winner = m_slot[k];
        cnt++;
      end
    end
    return cnt;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_table();
    for (int s = 0; s < NS; s++) begin
      t_en[s] = 0; t_x[s] = 0; t_y[s] = 0;
      for (int r = 0; r < 8; r++) t_bmp[s*8+r] = 8'($urandom);
    end
  endtask

  task automatic pulse_line(input int ny);
    next_y = 11'(ny); line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
`ifdef SPR_COLLISION_EN
    exp_coll = 0;
`endif
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL frame_clear: overflow=%0b expected 0", overflow);
    end
  endtask

  // Schedule row ny, then swap it in with a line_start c cycles later.
  task automatic run_line(input int ny, input int c);
    repeat (50) tick();
    pulse_frame();
    pulse_line(ny);
    model_scan(ny, c);
    if (c >= 1000) repeat (55) tick();
    else repeat (c - 1) tick();
    pulse_line(IDLE_Y);
    total++;
    if (overflow !== m_ovf) begin
      bad++; $display("FAIL overflow ny=%0d c=%0d: got %0b expected %0b", ny, c, overflow, m_ovf);
    end
    total++;
    if (attr_rd !== 1'b1 || attr_addr !== 4'd0) begin
      bad++; $display("FAIL scan_restart: attr_rd=%0b attr_addr=%0d expected 1/0", attr_rd, attr_addr);
    end
  endtask

  task automatic sweep(input string nm, input int h0, input int h1);
    int w, cnt;
    for (int h = h0; h <= h1; h++) begin
      horizontalPix = 12'(h);
      tick();
      cnt = model_count(h, w);
      if (w >= 0) exp_idx = w;
`ifdef SPR_COLLISION_EN
      if (cnt >= 2) exp_coll = 1;
`endif
      total++;
      if (pix_on !== (w >= 0) || pix_idx !== 4'(exp_idx)) begin
        bad++;
        $display("FAIL %s h=%0d: pix_on=%0b pix_idx=%0d expected %0b/%0d", nm, h, pix_on, pix_idx, w >= 0, exp_idx);
      end
    end
    horizontalPix = 12'(IDLE_H);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    exp_idx = 0; m_n = 0;
    total++;
    if (pix_on !== 1'b0 || pix_idx !== 4'd0 || overflow !== 1'b0 || attr_rd !== 1'b0 ||
        bmp_rd !== 1'b0 || attr_addr !== 4'd0 || bmp_addr !== 7'd0 || dut.state_q !== ST_IDLE) begin
      bad++;
      $display("FAIL reset: on=%0b idx=%0d ovf=%0b ard=%0b brd=%0b aa=%0d ba=%0d st=%0d expected all 0",
               pix_on, pix_idx, overflow, attr_rd, bmp_rd, attr_addr, bmp_addr, dut.state_q);
    end
  endtask

  task automatic test_single();
    clear_table();
    t_en[3] = 1; t_x[3] = 10; t_y[3] = 20; t_bmp[3*8+0] = 8'b1111_1100;
    run_line(20, 1000);
    sweep("single", 8, 18);
  endtask

  task automatic test_priority();
    clear_table();
    t_en[1] = 1; t_x[1] = 30; t_y[1] = 5; t_bmp[1*8+0] = 8'h0F;
    t_en[2] = 1; t_x[2] = 30; t_y[2] = 5; t_bmp[2*8+0] = 8'hFF;
    run_line(5, 1000);
    sweep("priority", 28, 40);
`ifdef SPR_COLLISION_EN
    total++;
    if (collision !== 1'b1) begin bad++; $display("FAIL collision: got %0b expected 1", collision); end
`endif
  endtask

  task automatic test_overflow();
    clear_table();
    for (int s = 0; s < 5; s++) begin
      t_en[s] = 1; t_x[s] = 50 + 10*s; t_y[s] = 40; t_bmp[s*8+0] = 8'hFF;
    end
    run_line(40, 1000);
    sweep("overflow_draw", 45, 100);
    pulse_frame();
  endtask

  task automatic test_negative();
    clear_table();
    t_en[6] = 1; t_x[6] = -4; t_y[6] = -3; t_bmp[6*8+5] = 8'hFF;
    run_line(2, 1000);
    total++;
    if (last_bmp_addr !== 7'h35) begin
      bad++; $display("FAIL neg_fetch: bmp_addr=%0h expected 35", last_bmp_addr);
    end
    sweep("negative", -6, 6);
  endtask

  task automatic test_late();
    clear_table();
    t_en[0] = 1; t_x[0] = 20; t_y[0] = 10; t_bmp[0*8+0] = 8'hFF;
    t_en[1] = 1; t_x[1] = 40; t_y[1] = 10; t_bmp[1*8+0] = 8'hFF;
    run_line(10, 6);
    sweep("late", 15, 50);
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int ny, c;
      clear_table();
      for (int s = 0; s < NS; s++) begin
        t_en[s] = bit'($urandom_range(0, 1));
        t_x[s]  = $urandom_range(0, 60);
        t_y[s]  = $urandom_range(0, 12);
      end
      ny = $urandom_range(0, 12);
      c  = ($urandom_range(0, 1) != 0) ? $urandom_range(2, 45) : 1000;
      run_line(ny, c);
      sweep("random", -2, 70);
`ifdef SPR_COLLISION_EN
      total++;
      if (collision !== exp_coll) begin
        bad++; $display("FAIL rand_collision: got %0b expected %0b", collision, exp_coll);
      end
`endif
    end
  endtask

  task automatic test_reset_mid_fetch();
    clear_table();
    t_en[0] = 1; t_x[0] = 100; t_y[0] = 50; t_bmp[0*8+0] = 8'hFF;
    run_line(50, 1000);
    sweep("pre_reset", 100, 100);
    horizontalPix = 12'd100;
    repeat (50) tick();
    pulse_line(50);
    tick(); tick();
    total++;
    if (bmp_rd !== 1'b1) begin bad++; $display("FAIL fetch_reached: bmp_rd=%0b expected 1", bmp_rd); end
    reset = 1'b1;
    tick();
    total++;
    if (dut.state_q !== ST_IDLE || bmp_rd !== 1'b0 || pix_on !== 1'b0) begin
      bad++; $display("FAIL reset_mid_fetch: st=%0d bmp_rd=%0b pix_on=%0b expected 0/0/0", dut.state_q, bmp_rd, pix_on);
    end
    reset = 1'b0;
    exp_idx = 0; m_n = 0;
`ifdef SPR_COLLISION_EN
    exp_coll = 0;
`endif
    sweep("after_reset", 98, 110);
    pulse_line(50);
    sweep("first_line", 98, 110);
    repeat (50) tick();
    model_scan(50, 1000);
    pulse_line(IDLE_Y);
    sweep("second_line", 98, 110);
  endtask

  initial begin
    reset = 1'b1; line_start = 1'b0; frame_start = 1'b0;
    next_y = 11'(IDLE_Y); horizontalPix = 12'(IDLE_H);
    exp_idx = 0; m_n = 0;
`ifdef SPR_COLLISION_EN
    exp_coll = 0;
`endif
    test_reset();
    test_single();
    test_priority();
    test_overflow();
    test_negative();
    test_late();
    test_random();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
